// File: rtl/ysyx_22040575_if_id_buf.sv
// ysyx_22040575_if_id_buf: 2-entry in-order IF/ID skid FIFO of {pc, inst} pairs.
// Ports:
//   clk        - clock, all state updates on posedge
//   reset      - synchronous active-low reset
//   in_valid   - fetch presents an instruction
//   in_ready   - buffer can accept an entry this cycle
//   in_pc      - PC of the presented instruction
//   in_inst    - presented instruction word
//   out_valid  - head entry available to decode
//   out_ready  - decode consumes the head this cycle
//   out_pc     - head PC (0 when empty)
//   out_inst   - head instruction (NOP when empty)
//   flush      - discard all entries
//   count      - occupancy 0..2
module ysyx_22040575_if_id_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic [DATA_WIDTH-1:0] in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    input  logic                  flush,
    output logic [1:0]            count
);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);
    logic [PC_WIDTH-1:0]   pc_mem   [2];
    logic [DATA_WIDTH-1:0] inst_mem [2];
    logic                  rd_ptr, wr_ptr, enq, deq;
    // in_ready depends only on occupancy and reset, never on out_ready
    assign in_ready  = (count != 2'd2) && reset;
    assign out_valid = count != 2'd0;
    assign enq       = in_valid && in_ready && !flush;
    assign deq       = out_valid && out_ready && !flush;
    assign out_pc    = out_valid ? pc_mem[rd_ptr] : '0;
    assign out_inst  = out_valid ? inst_mem[rd_ptr] : NOP;
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
            count <= count + 2'(enq) - 2'(deq);
        end
    end
    // storage is data-only and left unreset; enq already excludes reset and flush
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end
endmodule

// File: tb/tb_ysyx_22040575_if_id_buf.sv
// tb_ysyx_22040575_if_id_buf: table-driven bench for the IF/ID buffer plus streaming and full-stall sequences.
module tb_ysyx_22040575_if_id_buf;
    localparam logic [63:0] A  = 64'h8000_0000, B = 64'h8000_0004;
    localparam logic [63:0] C  = 64'h8000_0008, D = 64'h8000_000C;
    localparam logic [31:0] IA = 32'h0010_0093, IB = 32'h0020_0113;
    localparam logic [31:0] IC = 32'h0030_0193, ID = 32'h0040_0213;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, reset, in_valid, in_ready, out_valid, out_ready, flush;
    logic [63:0] in_pc, out_pc;
    logic [31:0] in_inst, out_inst;
    logic [1:0]  count;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    ysyx_22040575_if_id_buf #(.DATA_WIDTH(32), .PC_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .flush(flush), .count(count)
    );

    typedef struct {
        logic        rst, iv, ordy, fl;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        e_irdy, e_ov;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t v [20];

    function automatic vec_t mk(input logic rst, iv, input logic [63:0] pc, input logic [31:0] inst,
                                input logic ordy, fl, e_irdy, e_ov, input logic [63:0] e_pc,
                                input logic [31:0] e_inst, input logic [1:0] e_cnt);
        vec_t r;
        r.rst = rst; r.iv = iv; r.pc = pc; r.inst = inst; r.ordy = ordy; r.fl = fl;
        r.e_irdy = e_irdy; r.e_ov = e_ov; r.e_pc = e_pc; r.e_inst = e_inst; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // rst iv pc inst ordy fl | irdy ov pc inst cnt (outputs after the edge)
        v[0]  = mk(0, 1, A, IA, 0, 0,  0, 0, 0, NOP, 0);
        v[1]  = mk(1, 0, 0, 0,  0, 0,  1, 0, 0, NOP, 0);
        v[2]  = mk(1, 1, A, IA, 1, 0,  1, 1, A, IA,  1);
        v[3]  = mk(1, 0, 0, 0,  1, 0,  1, 0, 0, NOP, 0);
        v[4]  = mk(1, 1, A, IA, 0, 0,  1, 1, A, IA,  1);
        v[5]  = mk(1, 1, B, IB, 0, 0,  0, 1, A, IA,  2);
        v[6]  = mk(1, 1, C, IC, 0, 0,  0, 1, A, IA,  2);
        v[7]  = mk(1, 1, C, IC, 1, 0,  1, 1, B, IB,  1);
        v[8]  = mk(1, 0, 0, 0,  1, 0,  1, 0, 0, NOP, 0);
        v[9]  = mk(1, 0, 0, 0,  1, 0,  1, 0, 0, NOP, 0);
        v[10] = mk(1, 1, A, IA, 0, 0,  1, 1, A, IA,  1);
        v[11] = mk(1, 1, B, IB, 0, 0,  0, 1, A, IA,  2);
        v[12] = mk(1, 1, C, IC, 1, 1,  1, 0, 0, NOP, 0);
        v[13] = mk(1, 1, D, ID, 0, 0,  1, 1, D, ID,  1);
        v[14] = mk(1, 0, 0, 0,  1, 0,  1, 0, 0, NOP, 0);
        v[15] = mk(1, 1, A, IA, 0, 0,  1, 1, A, IA,  1);
        v[16] = mk(1, 1, B, IB, 0, 0,  0, 1, A, IA,  2);
        v[17] = mk(0, 1, C, IC, 1, 0,  0, 0, 0, NOP, 0);
        v[18] = mk(1, 0, 0, 0,  1, 0,  1, 0, 0, NOP, 0);
        v[19] = mk(1, 1, C, IC, 0, 0,  1, 1, C, IC,  1);

        reset = 0; in_valid = 0; in_pc = 0; in_inst = 0; out_ready = 0; flush = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            reset = v[i].rst; in_valid = v[i].iv; in_pc = v[i].pc; in_inst = v[i].inst;
            out_ready = v[i].ordy; flush = v[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d in_ready", i),  64'(in_ready),  64'(v[i].e_irdy));
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(v[i].e_ov));
            chk($sformatf("v%0d out_pc", i),    out_pc,         v[i].e_pc);
            chk($sformatf("v%0d out_inst", i),  64'(out_inst),  64'(v[i].e_inst));
            chk($sformatf("v%0d count", i),     64'(count),     64'(v[i].e_cnt));
        end

        // streaming from count=1: each cycle the new entry becomes the head
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            flush = 0; in_valid = 1; out_ready = 1;
            in_pc = C + 64'(4 * (i + 1)); in_inst = 32'h1000_0000 + 32'(i);
            #1;
            chk($sformatf("stream%0d in_ready", i), 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d count", i),    64'(count),    64'd1);
            chk($sformatf("stream%0d out_pc", i),   out_pc,        C + 64'(4 * (i + 1)));
            chk($sformatf("stream%0d out_inst", i), 64'(out_inst), 64'(32'h1000_0000 + 32'(i)));
        end

        // fill to 2, then out_ready=1 must not raise in_ready combinationally
        @(negedge clk);
        in_valid = 1; in_pc = 64'h8000_1000; in_inst = 32'h0060_0313; out_ready = 0;
        @(posedge clk);
        #1;
        chk("full count", 64'(count), 64'd2);
        @(negedge clk);
        in_valid = 1; in_pc = 64'h8000_2000; in_inst = 32'h0070_0393; out_ready = 1;
        #1;
        chk("full in_ready with out_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("after full deq count", 64'(count), 64'd1);
        chk("after full deq in_ready", 64'(in_ready), 64'd1);
        chk("after full deq out_pc", out_pc, 64'h8000_1000);
        chk("after full deq out_inst", 64'(out_inst), 64'(32'h0060_0313));

        @(negedge clk);
        in_valid = 0; out_ready = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22040575_if_id_buf.md
YSYX_22040575_IF_ID_BUF -- requirements
Module: ysyx_22040575_if_id_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the instruction width.
REQ-002 SHALL have parameter PC_WIDTH, default 64, giving the PC width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on posedge clk).
REQ-005 SHALL have port in_valid, input, 1 bit: upstream fetch stage presents an instruction.
REQ-006 SHALL have port in_ready, output, 1 bit: buffer can accept an entry this cycle.
REQ-007 SHALL have port in_pc, input, PC_WIDTH bits: PC of the presented instruction.
REQ-008 SHALL have port in_inst, input, DATA_WIDTH bits: the presented instruction word.
REQ-009 SHALL have port out_valid, output, 1 bit: head entry is available to the decode stage.
REQ-010 SHALL have port out_ready, input, 1 bit: decode stage consumes the head this cycle.
REQ-011 SHALL have port out_pc, output, PC_WIDTH bits: PC of the head entry.
REQ-012 SHALL have port out_inst, output, DATA_WIDTH bits: instruction of the head entry.
REQ-013 SHALL have port flush, input, 1 bit: redirect from the execute stage that discards all entries.
REQ-014 SHALL have port count, output, 2 bits: current occupancy, 0..2.

Function
REQ-015 SHALL be a 2-entry, in-order FIFO of {pc, inst} pairs, with 1-bit read and write pointers that wrap 1->0.
REQ-016 SHALL enqueue in_pc/in_inst at posedge clk when in_valid && in_ready.
REQ-017 SHALL dequeue the head at posedge clk when out_valid && out_ready.
REQ-018 SHALL drive in_ready = (count != 2) && reset, with no combinational dependence on out_ready.
REQ-019 SHALL drive out_valid = (count != 0).
REQ-020 SHALL drive out_pc and out_inst from the head storage entry.
REQ-021 SHALL force out_inst to 32'h0000_0013 (NOP) and out_pc to 0 while out_valid = 0.
REQ-022 SHALL provide no input-to-output bypass: an entry accepted at edge N is first visible at out_* after edge N, so minimum latency is 1 cycle.
REQ-023 SHALL update occupancy as follows: enqueue only -> count+1; dequeue only -> count-1; both -> unchanged, with the head advancing and the new entry written at the tail.
REQ-024 SHALL, when count = 2, hold in_ready = 0 even if out_ready = 1; a dequeue in that cycle makes in_ready = 1 the next cycle.
REQ-025 SHALL, when count = 0, ignore out_ready, leaving the pointers unchanged.
REQ-026 SHALL give flush priority over everything: at the edge where flush = 1, count -> 0, both pointers -> 0, and any simultaneous enqueue or dequeue is discarded.
REQ-027 SHALL hold out_valid = 0 in the cycle after a flush, with in_ready = 1.
REQ-028 SHALL NOT modify the held entries while out_valid = 1 and out_ready = 0; out_pc/out_inst stay stable (valid-hold rule).
REQ-029 SHALL ignore in_pc/in_inst values when in_valid = 0.

Reset
REQ-030 SHALL, on a posedge with reset = 0, set count = 0 and both pointers = 0, so out_valid = 0, out_pc = 0 and out_inst = 32'h0000_0013.
REQ-031 SHALL hold in_ready = 0 while reset = 0 and ignore in_valid, out_ready and flush during reset.
REQ-032 SHALL, when reset asserts with entries held mid-operation, discard them at that edge; no stale entry reappears after reset deasserts.
REQ-033 SHALL leave storage contents uninitialised; only the control state requires reset.

Verification
REQ-034 SHALL cover single pass: in {pc=0x80000000, inst=0x00100093} accepted at edge 1 with out_ready = 1 -> out_valid = 1 after edge 1 with the same values, count = 0 after edge 2.
REQ-035 SHALL cover fill and stall: with out_ready = 0, push 0x80000000 then 0x80000004 -> count = 2, in_ready = 0, out_pc = 0x80000000 held; a third push is not accepted.
REQ-036 SHALL cover full with simultaneous ready: count = 2, out_ready = 1, in_valid = 1 -> no enqueue that cycle, count = 1 after the edge, out_pc = 0x80000004, in_ready = 1.
REQ-037 SHALL cover steady streaming: in_valid = out_ready = 1 for 8 cycles with pc += 4 -> count stays 1 and out_pc sequence = input sequence delayed by one cycle, no drops.
REQ-038 SHALL cover flush with enqueue: count = 2 and flush = 1 with in_valid = 1 at the same edge -> count = 0, out_valid = 0, out_inst = 0x00000013; the next accepted pc appears first.
REQ-039 SHALL cover reset mid-operation: count = 2, then reset = 0 for 1 cycle -> count = 0 and in_ready = 0 during reset, in_ready = 1 after release, and the old pcs are never output.
